// File: rtl/rank_sort_engine.sv
// Purpose : stable rank sort of an N-element frame of unsigned WIDTH-bit
//           values into ascending or descending order. Optional macro
//           RANK_SORT_INDEX_EN adds out_index, which gives the original
//           load position of each output element.
// Latency : the first out_valid comes N+1 cycles after the last accept.
//           The core ranks one element per cycle for N cycles, then uses
//           one cycle to register the first output.
// Backpressure: in_ready is high only in LOAD. While out_ready is low in
//           DRAIN, out_data, out_last and out_index are held.
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/in_data/
//           descend (load side); out_valid/out_ready/out_data/out_last
//           (drain side); busy (RANK or DRAIN); [out_index]
module rank_sort_engine #(
    parameter int N     = 6,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 descend,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
`ifdef RANK_SORT_INDEX_EN
    output logic [$clog2(N)-1:0] out_index,
`endif
    output logic                 busy
);

    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {LOAD, RANK, DRAIN} state_t;

    state_t           state;
    logic [RW-1:0]    k;        // load index in LOAD, element being ranked in RANK
    logic [RW-1:0]    o;        // output index in DRAIN
    logic [RW-1:0]    o_nxt;
    logic [RW-1:0]    rank;
    logic             desc_q;   // order latched at the first accept of the frame
    logic [WIDTH-1:0] load_buf [N];
    logic [WIDTH-1:0] sort_buf [N];
`ifdef RANK_SORT_INDEX_EN
    logic [RW-1:0]    idx_buf  [N];
`endif

    assign in_ready = rst_n && (state == LOAD);
    assign busy     = rst_n && (state != LOAD);
    assign o_nxt    = o + RW'(1);

    // Count the elements that sort strictly ahead of element k. If two keys
    // are equal, the earlier-loaded one goes first. This keeps the sort stable
    // and makes the ranks a permutation of 0..N-1.
    always_comb begin
        rank = '0;
        for (int j = 0; j < N; j++) begin
            if (j != int'(k)) begin
                if (desc_q ? (load_buf[j] > load_buf[k]) : (load_buf[j] < load_buf[k]))
                    rank = rank + RW'(1);
                else if ((load_buf[j] == load_buf[k]) && (j < int'(k)))
                    rank = rank + RW'(1);
            end
        end
    end

    // The data buffers are not reset. A reset only abandons the frame that
    // is in flight.
    always_ff @(posedge clk) begin
        if (rst_n && state == LOAD && in_valid)
            load_buf[k] <= in_data;
        if (rst_n && state == RANK) begin
            sort_buf[rank] <= load_buf[k];
`ifdef RANK_SORT_INDEX_EN
            idx_buf[rank]  <= k;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            k         <= '0;
            o         <= '0;
            desc_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
`ifdef RANK_SORT_INDEX_EN
            out_index <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (k == '0)
                            desc_q <= descend;
                        if (k == RW'(N - 1)) begin
                            k     <= '0;
                            state <= RANK;
                        end else begin
                            k <= k + RW'(1);
                        end
                    end
                end
                RANK: begin
                    if (k == RW'(N - 1)) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + RW'(1);
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        // First DRAIN cycle: sort_buf is complete, so present slot 0.
                        out_valid <= 1'b1;
                        out_data  <= sort_buf[0];
                        out_last  <= 1'b0;
`ifdef RANK_SORT_INDEX_EN
                        out_index <= idx_buf[0];
`endif
                    end else if (out_ready) begin
                        if (out_last) begin
                            state     <= LOAD;
                            o         <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
`ifdef RANK_SORT_INDEX_EN
                            out_index <= '0;
`endif
                        end else begin
                            o         <= o_nxt;
                            out_data  <= sort_buf[o_nxt];
                            out_last  <= (o_nxt == RW'(N - 1));
`ifdef RANK_SORT_INDEX_EN
                            out_index <= idx_buf[o_nxt];
`endif
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_rank_sort_engine.sv
module tb_rank_sort_engine;

    localparam int N = 6;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         descend = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
`ifdef RANK_SORT_INDEX_EN
    logic [2:0]   out_index;
`endif

    rank_sort_engine #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .descend   (descend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef RANK_SORT_INDEX_EN
        .out_index (out_index),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_acc  = 0;

    typedef struct packed {
        logic [5:0][7:0] din;
        logic            desc;
        logic            gaps;
        logic            toggle;
        logic [2:0]      stall_at;   // 7 = no stall
        logic [5:0][7:0] dout;
        logic [5:0][2:0] idx;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0][7:0] p6(input int a, b, c, d, e, f);
        logic [5:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c);
        r[3] = 8'(d); r[4] = 8'(e); r[5] = 8'(f);
        return r;
    endfunction

    function automatic logic [5:0][2:0] q6(input int a, b, c, d, e, f);
        logic [5:0][2:0] r;
        r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c);
        r[3] = 3'(d); r[4] = 3'(e); r[5] = 3'(f);
        return r;
    endfunction

    // Reference model: stable insertion sort of (value, position) pairs.
    task automatic model(input logic [5:0][7:0] v, input logic desc,
                         output logic [5:0][7:0] e, output logic [5:0][2:0] ei);
        int val[6];
        int ix[6];
        int tv;
        int ti;
        for (int i = 0; i < 6; i++) begin
            val[i] = int'(v[i]);
            ix[i]  = i;
        end
        for (int i = 1; i < 6; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (val[j] > val[j-1]) : (val[j] < val[j-1])) begin
                    tv = val[j]; val[j] = val[j-1]; val[j-1] = tv;
                    ti = ix[j];  ix[j]  = ix[j-1];  ix[j-1]  = ti;
                end else begin
                    break;
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            e[i]  = 8'(val[i]);
            ei[i] = 3'(ix[i]);
        end
    endtask

    // Load one frame. Afterwards in_valid stays high with junk data,
    // so the bench can show that it is ignored outside LOAD.
    task automatic send_frame(input logic [5:0][7:0] v, input logic desc,
                              input logic gaps, input logic toggle);
        int to;
        for (int i = 0; i < N; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                step();
                step();
            end
            in_valid = 1'b1;
            in_data  = v[i];
            descend  = (toggle && i > 0) ? ~desc : desc;
            to = 0;
            while (!in_ready && to < 50) begin
                step();
                to++;
            end
            if (to >= 50) chk("in_ready_timeout", 0, 1);
            step();
            t_acc = cyc;
        end
        in_data = 8'($urandom);
        descend = 1'($urandom_range(0, 1));
    endtask

    task automatic recv_frame(input logic [5:0][7:0] e, input logic [5:0][2:0] ei,
                              input int stall_at);
        int to;
        logic [7:0] held;
        out_ready = 1'b1;
        to = 0;
        while (!out_valid && to < 60) begin
            chk("busy_before_out", busy, 1);
            step();
            to++;
        end
        in_valid = 1'b0;
        chk("first_valid", out_valid, 1);
        if (!out_valid) return;
        chk("latency", cyc - t_acc, N + 1);
        for (int n = 0; n < N; n++) begin
            chk("valid_run", out_valid, 1);
            if (n == stall_at) begin
                out_ready = 1'b0;
                held = out_data;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("stall_data", out_data, held);
                    chk("stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            chk("out_data", out_data, e[n]);
            chk("out_last", out_last, (n == N - 1));
`ifdef RANK_SORT_INDEX_EN
            chk("out_index", out_index, ei[n]);
`endif
            step();
        end
        chk("valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("data_after", out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0][7:0] e;
        logic [5:0][2:0] ei;
        logic [5:0][7:0] v;
        logic            d;
        int              bad;

        tbl[0] = '{din: p6(5,3,9,1,7,2), desc: 1'b0, gaps: 1'b0, toggle: 1'b0, stall_at: 3'd7,
                   dout: p6(1,2,3,5,7,9), idx: q6(3,5,1,0,4,2)};
        tbl[1] = '{din: p6(5,3,9,1,7,2), desc: 1'b1, gaps: 1'b0, toggle: 1'b0, stall_at: 3'd7,
                   dout: p6(9,7,5,3,2,1), idx: q6(2,4,0,1,5,3)};
        tbl[2] = '{din: p6(4,4,1,4,0,1), desc: 1'b0, gaps: 1'b0, toggle: 1'b0, stall_at: 3'd7,
                   dout: p6(0,1,1,4,4,4), idx: q6(4,2,5,0,1,3)};
        tbl[3] = '{din: p6(5,3,9,1,7,2), desc: 1'b0, gaps: 1'b0, toggle: 1'b0, stall_at: 3'd2,
                   dout: p6(1,2,3,5,7,9), idx: q6(3,5,1,0,4,2)};
        tbl[4] = '{din: p6(255,0,255,0,128,1), desc: 1'b0, gaps: 1'b1, toggle: 1'b1, stall_at: 3'd7,
                   dout: p6(0,0,1,128,255,255), idx: q6(1,3,5,4,0,2)};

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        step();

        // Directed table
        for (int t = 0; t < 5; t++) begin
            send_frame(tbl[t].din, tbl[t].desc, tbl[t].gaps, tbl[t].toggle);
            recv_frame(tbl[t].dout, tbl[t].idx, int'(tbl[t].stall_at));
            step();
        end

        // Reset while the frame is in RANK: the frame must be dropped
        send_frame(p6(5,3,9,1,7,2), 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rank_busy", busy, 1);
        chk("rank_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        chk("abandoned_frame_quiet", bad, 0);
        send_frame(p6(6,5,4,3,2,1), 1'b0, 1'b0, 1'b0);
        recv_frame(p6(1,2,3,4,5,6), q6(5,4,3,2,1,0), 7);

        // Random frames, checked against the reference model
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 6; i++)
                v[i] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            d = 1'($urandom_range(0, 1));
            model(v, d, e, ei);
            send_frame(v, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            recv_frame(e, ei, int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rank_sort_engine.md
RANK_SORT_ENGINE -- requirements
Module: rank_sort_engine

Interface
REQ-001 The block SHALL have the parameter N, default 6, meaning the number of elements per sort frame (legal range N >= 2).
REQ-002 The block SHALL have the parameter WIDTH, default 8, meaning the unsigned element width in bits (legal range WIDTH >= 1).
REQ-003 The block SHALL have the port clk  input  1  meaning the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have the port rst_n  input  1  meaning a synchronous, active-low reset.
REQ-005 The block SHALL have the port in_valid  input  1  meaning in_data is valid this cycle.
REQ-006 The block SHALL have the port in_ready  output  1  meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have the port in_data  input  WIDTH  meaning one unsigned frame element.
REQ-008 The block SHALL have the port descend  input  1  meaning 0 = ascending order and 1 = descending order.
REQ-009 The block SHALL have the port out_valid  output  1  meaning out_data is valid this cycle.
REQ-010 The block SHALL have the port out_ready  input  1  meaning downstream accepts out_data this cycle.
REQ-011 The block SHALL have the port out_data  output  WIDTH  meaning one sorted element.
REQ-012 The block SHALL have the port out_last  output  1  meaning out_data is the final element of the frame.
REQ-013 The block SHALL have the port busy  output  1  meaning the state is RANK or DRAIN.

Function
REQ-014 The block SHALL use three states: LOAD, RANK and DRAIN.
REQ-015 In LOAD the block SHALL drive in_ready=1, store in_data at load index k on each in_valid&&in_ready, and increment k.
REQ-016 The block SHALL sample descend on the first accept of a frame (k=0) and hold it until the frame's out_last handshake.
REQ-017 On the Nth accept the block SHALL move to RANK on the next edge with k reset to 0; gaps in in_valid only stall loading.
REQ-018 In RANK the block SHALL process one element per cycle, so that the state lasts exactly N cycles, with in_ready=0.
REQ-019 The rank of element k SHALL be the count of j != k satisfying key_j<key_k (ascending) or key_j>key_k (descending), plus the count of j<k with key_j==key_k (stable tie-break).
REQ-020 The block SHALL write element k to sorted buffer slot rank(k), and ranks SHALL form a permutation of 0..N-1.
REQ-021 Comparisons SHALL be unsigned over the full WIDTH, and each rank counter SHALL be $clog2(N) bits wide, since it never exceeds N-1.
REQ-022 After RANK the block SHALL enter DRAIN, where out_valid=1 and out_data=buffer[o] for output index o.
REQ-023 The block SHALL advance o only on out_valid&&out_ready, and out_data SHALL be held stable while out_ready=0.
REQ-024 The block SHALL assert out_last when o==N-1, and on that handshake SHALL return to LOAD with o=0.
REQ-025 Latency SHALL be N+1 cycles: the last input accepted at edge t SHALL give out_valid=1 in the cycle after edge t+N+1.
REQ-026 The block SHALL ignore in_valid outside LOAD, with no side effects.
REQ-027 Frames SHALL NOT overlap: the next frame's first accept SHALL occur no earlier than the cycle after the out_last handshake.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set the state to LOAD, k=0 and o=0, and drive in_ready=0, out_valid=0, out_last=0 and busy=0.
REQ-029 The block SHALL drive out_data=0 while in reset and in LOAD, and SHALL leave buffer contents unreset.
REQ-030 A reset during RANK or DRAIN SHALL abandon the frame, so that no further out_valid occurs for it.
REQ-031 The block SHALL drive in_ready=1 in the first cycle after rst_n returns high.

Configuration
REQ-032 When RANK_SORT_INDEX_EN is defined, the block SHALL add an output port out_index, $clog2(N) bits wide, that carries the original load position of out_data and is valid with out_valid.
REQ-033 When RANK_SORT_INDEX_EN is undefined, the block SHALL NOT have the out_index port or its index buffer, and all other behaviour SHALL be identical.

Verification
REQ-034 With N=6, WIDTH=8, input 5,3,9,1,7,2 and descend=0, the bench SHALL check for the output 1,2,3,5,7,9, out_last on the 9, and first out_valid 7 cycles after the last accept.
REQ-035 With the same input and descend=1, the bench SHALL check for the output 9,7,5,3,2,1.
REQ-036 With input 4,4,1,4,0,1 and ascending order, the bench SHALL check for the output 0,1,1,4,4,4 and, with RANK_SORT_INDEX_EN, out_index 4,2,5,0,1,3.
REQ-037 With out_ready held low for 3 cycles at o=2, the bench SHALL check that out_data is stable, o does not advance, and no element is lost or duplicated.
REQ-038 With input 255,0,255,0,128,1 and in_valid gaps, the bench SHALL check for the output 0,0,1,128,255,255, with descend toggled mid-load ignored.
REQ-039 With rst_n pulsed low for 1 cycle during RANK, the bench SHALL check that out_valid stays 0, and that a following frame 6,5,4,3,2,1 sorts to 1..6.
